jtframe_line_doubler: RTL and testbench



---
 rtl/jtframe_video_pkg.sv | 18 +
 rtl/jtframe_linebuf_ram.sv | 32 +++
 rtl/jtframe_line_doubler.sv | 131 +++++++++++++
 tb/tb_jtframe_line_doubler.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_video_pkg.sv
// rtl/jtframe_video_pkg.sv - shared video constants and address-width helper
package jtframe_video_pkg;

    localparam int DEF_DW   = 12;
    localparam int DEF_HLEN = 384;
    localparam int DEF_HSW  = 6;

    // Number of bits needed to address 'value' distinct locations
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/jtframe_linebuf_ram.sv
// rtl/jtframe_linebuf_ram.sv - two-bank line buffer, one write port, one registered read port
module jtframe_linebuf_ram
    import jtframe_video_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int HLEN = DEF_HLEN,
    parameter int AW   = clog2(DEF_HLEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW:0]   waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW:0]   raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:1][0:HLEN-1];

    // Write port: address is {bank, pixel address}; contents survive reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr[AW]][waddr[AW-1:0]] <= wdata;
    end

    // Registered read port; only the output register is cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr[AW]][raddr[AW-1:0]];
    end

endmodule

// File: rtl/jtframe_line_doubler.sv
// rtl/jtframe_line_doubler.sv - ping-pong line buffer scan doubler (15 kHz to 31 kHz)
module jtframe_line_doubler
    import jtframe_video_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int HLEN = DEF_HLEN,
    parameter int HSW  = DEF_HSW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          base_cen,
    input  logic          basex2_cen,
    input  logic [DW-1:0] base_pxl,
    input  logic          HS,
    output logic [DW-1:0] x2_pxl,
    output logic          x2_HS
);

    localparam int AW = clog2(HLEN);
    localparam int CW = clog2(HLEN + 1);
    localparam logic [AW-1:0] ADDR_MAX = AW'(HLEN - 1);
    localparam logic [CW-1:0] LEN_MAX  = CW'(HLEN);
    localparam logic [CW-1:0] LEN_MIN  = CW'(2);

    logic            wbank;
    logic [AW-1:0]   wr_addr;
    logic [CW-1:0]   hcnt;
    logic [CW-1:0]   line_len;
    logic [HSW-1:0]  hs_width;
    logic [HSW-1:0]  hs_cnt;
    logic            HS_last;
    logic            primed;
    logic            restart_pend;
    logic            rd_bank;
    logic [AW-1:0]   rd_addr;
    logic [HSW-1:0]  x2_hs_cnt;

    logic            line_start;
    logic            wr_bank;
    logic [AW-1:0]   wr_ptr;
    logic            wrap;

    assign line_start = HS & ~HS_last;
    // The first pixel of a new line goes straight to address 0 of the freshly toggled bank
    assign wr_bank    = line_start ? ~wbank : wbank;
    assign wr_ptr     = line_start ? '0 : wr_addr;
    assign wrap       = ({1'b0, CW'(rd_addr)} + (CW+1)'(1)) >= {1'b0, line_len};

    // Input side: line detection, write addressing, line length and HS width measurement
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wbank    <= 1'b0;
            wr_addr  <= '0;
            hcnt     <= '0;
            line_len <= LEN_MAX;
            hs_width <= '0;
            hs_cnt   <= '0;
            HS_last  <= 1'b0;
            primed   <= 1'b0;
        end else if (base_cen) begin
            HS_last <= HS;
            if (line_start) begin
                wbank    <= ~wbank;
                line_len <= (hcnt < LEN_MIN) ? LEN_MIN : hcnt;
                hcnt     <= CW'(1);
                wr_addr  <= AW'(1);
                primed   <= 1'b1;
            end else begin
                if (wr_addr != ADDR_MAX) wr_addr <= wr_addr + AW'(1);
                if (hcnt != LEN_MAX)     hcnt    <= hcnt + CW'(1);
            end
            if (HS) begin
                if (hs_cnt != '1) hs_cnt <= hs_cnt + HSW'(1);
            end else if (HS_last) begin
                hs_width <= hs_cnt;
                hs_cnt   <= '0;
            end
        end
    end

    // A line start is remembered until the next output tick, which restarts the read
    always_ff @(posedge clk) begin
        if (!rst_n)                        restart_pend <= 1'b0;
        else if (base_cen && line_start)   restart_pend <= 1'b1;
        else if (basex2_cen)               restart_pend <= 1'b0;
    end

    // Output side: read address sweep, bank follow-up at restart, HS regeneration per pass
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_addr   <= '0;
            rd_bank   <= 1'b1;
            x2_hs_cnt <= '0;
            x2_HS     <= 1'b0;
        end else if (basex2_cen) begin
            if (restart_pend) begin
                rd_addr <= '0;
                rd_bank <= ~wbank;
            end else if (wrap) begin
                rd_addr <= '0;
            end else begin
                rd_addr <= rd_addr + AW'(1);
            end
            if (primed && rd_addr == '0) begin
                x2_HS     <= |hs_width;
                x2_hs_cnt <= (|hs_width) ? hs_width - HSW'(1) : '0;
            end else if (|x2_hs_cnt) begin
                x2_HS     <= 1'b1;
                x2_hs_cnt <= x2_hs_cnt - HSW'(1);
            end else begin
                x2_HS     <= 1'b0;
            end
        end
    end

    jtframe_linebuf_ram #(
        .DW   (DW),
        .HLEN (HLEN),
        .AW   (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (base_cen & rst_n),
        .waddr ({wr_bank, wr_ptr}),
        .wdata (base_pxl),
        .re    (basex2_cen & primed),
        .raddr ({rd_bank, rd_addr}),
        .rdata (x2_pxl)
    );

endmodule

// File: tb/tb_jtframe_line_doubler.sv
// tb/tb_jtframe_line_doubler.sv - randomized bench for jtframe_line_doubler against a line-level model
module tb_jtframe_line_doubler;

    localparam int DW   = 12;
    localparam int HLEN = 384;
    localparam int HSW  = 6;
    localparam int NS   = 16384;
    localparam int ML   = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          base_cen = 1'b0;
    logic          basex2_cen = 1'b0;
    logic [DW-1:0] base_pxl = '0;
    logic          HS = 1'b0;
    logic [DW-1:0] x2_pxl;
    logic          x2_HS;

    jtframe_line_doubler #(.DW(DW), .HLEN(HLEN), .HSW(HSW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .base_cen   (base_cen),
        .basex2_cen (basex2_cen),
        .base_pxl   (base_pxl),
        .HS         (HS),
        .x2_pxl     (x2_pxl),
        .x2_HS      (x2_HS)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    bit       stall = 1'b0;
    logic [2:0] ph = '0;
    int       x2_cnt = 0;
    int       mon_idx;

    logic [DW-1:0] smp_pxl [0:NS-1];
    logic          smp_hs  [0:NS-1];
    logic [DW-1:0] exp_px  [0:NS-1];
    bit            exp_hs  [0:NS-1];
    bit            exp_v   [0:NS-1];

    int            ln_n  [0:ML-1];
    int            ln_w  [0:ML-1];
    int            ln_t0 [0:ML-1];
    int            ln_ep [0:ML-1];
    bit            ln_ok [0:ML-1];
    logic [DW-1:0] ln_px [0:ML-1][0:399];
    int            nlines = 0;
    int            epoch = 0;

    int            stall_idx = -1;
    logic [DW-1:0] stall_pxl;
    logic          stall_hs;

    int c_len, c_cnt, c_a, c_idx, c_w;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Enable generator: base tick at phase 2 of 8, output tick at phases 0 and 4
    initial forever begin
        @(posedge clk);
        #1;
        if (!stall) ph = ph + 3'd1;
        base_cen   = !stall && (ph == 3'd2);
        basex2_cen = !stall && (ph[1:0] == 2'd0);
    end

    // Output monitor: records the doubled stream once per output tick
    initial forever begin
        @(posedge clk);
        if (basex2_cen) begin
            mon_idx = x2_cnt;
            x2_cnt++;
            #3;
            if (mon_idx < NS) begin
                smp_pxl[mon_idx] = x2_pxl;
                smp_hs[mon_idx]  = x2_HS;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic wait_base();
        do begin
            @(posedge clk);
            #2;
        end while (!base_cen);
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        HS    = 1'b0;
        @(posedge clk);
        #3;
        check("mid_rst_pxl", 32'(x2_pxl), 32'd0);
        check("mid_rst_hs", 32'(x2_HS), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        wait_base();
        wait_base();
        check("post_rst_pxl", 32'(x2_pxl), 32'd0);
        check("post_rst_hs", 32'(x2_HS), 32'd0);
        epoch++;
    endtask

    task automatic send_line(input int n, input int w, input bit use_idx, input int rst_at, input int stall_at);
        int k;
        logic [DW-1:0] px;
        k = nlines;
        nlines++;
        ln_n[k]  = n;
        ln_w[k]  = w;
        ln_ep[k] = epoch;
        ln_ok[k] = 1'b0;
        for (int i = 0; i < n; i++) begin
            wait_base();
            if (i == rst_at) begin
                mid_reset();
                return;
            end
            if (i == 0) ln_t0[k] = x2_cnt;
            px = use_idx ? DW'(i) : DW'($urandom);
            HS = (i < w);
            base_pxl = px;
            ln_px[k][i] = px;
            if (i == stall_at) begin
                stall = 1'b1;
                @(posedge clk);
                repeat (100) @(posedge clk);
                #3;
                stall_idx = x2_cnt - 1;
                stall_pxl = x2_pxl;
                stall_hs  = x2_HS;
                stall = 1'b0;
            end
        end
        ln_ok[k] = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            HS = 1'($urandom);
            base_pxl = DW'($urandom);
            #1;
            check("rst_pxl", 32'(x2_pxl), 32'd0);
            check("rst_hs", 32'(x2_HS), 32'd0);
        end
        HS = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        wait_base();
        wait_base();
        check("idle_pxl", 32'(x2_pxl), 32'd0);
        check("idle_hs", 32'(x2_HS), 32'd0);

        for (int i = 0; i < 3; i++) send_line(384, 32, 1'b1, -1, -1);
        send_line(300, $urandom_range(4, 40), 1'b0, -1, -1);
        send_line(384, $urandom_range(4, 40), 1'b0, -1, -1);
        send_line(400, $urandom_range(4, 40), 1'b0, -1, -1);
        send_line(384, $urandom_range(4, 40), 1'b0, -1, -1);
        send_line(384, 32, 1'b0, 75, -1);
        for (int i = 0; i < 3; i++) send_line(384, $urandom_range(4, 40), 1'b0, -1, -1);
        send_line(384, $urandom_range(4, 40), 1'b0, -1, 200);
        for (int i = 0; i < 4; i++) send_line($urandom_range(300, 400), $urandom_range(4, 40), 1'b0, -1, -1);
        send_line(384, 20, 1'b0, -1, -1);
        repeat (40) @(posedge clk);

        // Line k is shown twice while line k+1 is being received
        for (int k = 0; k < nlines - 1; k++) begin
            if (ln_ok[k] && ln_ok[k+1] && ln_ep[k] == ln_ep[k+1]) begin
                c_len = (ln_n[k] > HLEN) ? HLEN : ln_n[k];
                c_cnt = (2 * c_len < 2 * ln_n[k+1]) ? 2 * c_len : 2 * ln_n[k+1];
                for (int i = 0; i < c_cnt; i++) begin
                    c_idx = ln_t0[k+1] + 1 + i;
                    c_a   = i % c_len;
                    c_w   = (i < c_len) ? ln_w[k] : ln_w[k+1];
                    if (c_idx < NS) begin
                        exp_px[c_idx] = (ln_n[k] > HLEN && c_a == HLEN - 1) ? ln_px[k][ln_n[k]-1] : ln_px[k][c_a];
                        exp_hs[c_idx] = (c_a < c_w);
                        exp_v[c_idx]  = 1'b1;
                    end
                end
            end
        end
        for (int i = 0; i < NS; i++) begin
            if (i < x2_cnt && exp_v[i])
                check($sformatf("x2[%0d]", i), {19'd0, smp_hs[i], smp_pxl[i]}, {19'd0, exp_hs[i], exp_px[i]});
        end
        if (stall_idx >= 0 && stall_idx < NS && exp_v[stall_idx])
            check("stall_hold", {19'd0, stall_hs, stall_pxl}, {19'd0, exp_hs[stall_idx], exp_px[stall_idx]});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
